// File: rtl/timer_dev_pkg.sv
// Shared types and register-map constants for the memory-mapped countdown timer.
package timer_dev_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Word offsets within the timer window, taken from Addr[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // CTRL layout: [3] IM, [2:1] Mode, [0] Enable
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, load/count FSM and
// an expiry flag that drives IRQ to CP0 when unmasked.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              IRQ
);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  logic hit;
  logic wr_ctrl;
  logic wr_preset;
  logic unused_ok;

  assign hit       = (Addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl   = WE && hit && (Addr[3:2] == OFF_CTRL);
  assign wr_preset = WE && hit && (Addr[3:2] == OFF_PRESET);
  assign unused_ok = ^{Addr[1:0], Din};

  // State and register updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      if (wr_preset) preset_q <= CNT_W'(Din);
    end
  end

  // Next-state, count and flag logic; a CTRL write overrides the FSM's own Enable clear
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    count_d = count_q;
    flag_d  = flag_q;

    if (wr_ctrl || wr_preset) flag_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_PERIODIC) begin
          flag_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling through CTRL stops immediately and freezes COUNT
    if (wr_ctrl) begin
      ctrl_d = ctrl_t'(Din[3:0]);
      if (!Din[0]) begin
        state_d = ST_IDLE;
        count_d = count_q;
        flag_d  = 1'b0;
      end
    end
  end

  // Read mux, zero-extended; anything outside the three registers reads 0
  always_comb begin
    Dout = '0;
    if (hit) begin
      case (Addr[3:2])
        OFF_CTRL:   Dout = DATA_W'(ctrl_q);
        OFF_PRESET: Dout = DATA_W'(preset_q);
        OFF_COUNT:  Dout = DATA_W'(count_q);
        default:    Dout = '0;
      endcase
    end
  end

  assign IRQ = flag_q & ctrl_q.im;

endmodule
